psx_pad_emulator: RTL
=====================

# psx_pad_emulator

Controller-side endpoint of the PSX link: the digital pad that the host poller clocks. Oversamples `psx_clk`, `att` and `cmd` on the system clock, decodes the host's command bytes LSB-first, and shifts back the five-byte digital-pad response on `data`. It pulses `ack` low after every byte except the last, so the host poller can run in loopback against it on the same board without a real controller.

## Interface
- `ACK_DELAY`, 2: `clk` cycles from byte completion to `ack` falling.
- `ACK_LEN`, 2: `clk` cycles `ack` is held low (≥1).
- `ID_BYTE`, 8'h41: pad ID returned in byte 1 (digital pad).
- `clk` in 1: system clock, faster than 4× `psx_clk`.
- `rst` in 1: reset, synchronous and active-high.
- `psx_clk` in 1: host serial clock, async.
- `att` in 1: host attention, active-low, async.
- `cmd` in 1: host command bit, async.
- `buttons` in 16: pressed = 1; bit 0 → response byte 3 bit 0, bit 15 → byte 4 bit 7.
- `data` out 1: serial response, LSB first, idles 1.
- `ack` out 1: active-low acknowledge pulse, idles 1.
- `polled` out 1: one-cycle strobe on completion of a valid 5-byte poll.

## Operation
- `psx_clk`, `att`, `cmd` pass through 2-flop synchronizers; edges are detected on the synchronized signals.
- FSM states:
  - IDLE: `data`=1. On `att` falling, load tx byte 0 (8'hFF), clear the bit and byte counters, and go to XFER.
  - XFER:
    - On `psx_clk` falling: drive `data` ← tx[0] and shift tx right.
    - On `psx_clk` rising: shift `cmd` into rx at the MSB, so that after 8 bits rx holds the byte LSB-first.
    - After the 8th rising edge, the byte is complete:
      - Byte 0: rx ≠ 8'h01 → IGNORE.
      - Byte 1: rx ≠ 8'h42 → IGNORE.
      - Bytes 2–3: rx is don't-care.
      - Bytes 0–3: load the next tx byte and arm the ack timer.
      - Byte 4: no ack; go to DONE with `polled`=1 for one cycle.
  - IGNORE: `data`=1, no ack, incoming bits discarded, until `att` rises.
  - DONE: `data`=1, until `att` rises.
- Response sequence: 8'hFF, `ID_BYTE`, 8'h5A, ~snap[7:0], ~snap[15:8].
- `snap` captures `buttons` at byte 1 completion, so both button bytes come from one coherent sample.
- Ack timer: counts `ACK_DELAY` cycles, drives `ack`=0 for `ACK_LEN` cycles, then 1. It runs independently of bit shifting, and further `psx_clk` edges do not cancel it.
- `att` rising in any state, including mid-byte or mid-ack, goes to IDLE next cycle: `data`=1, `ack`=1, timer cleared, no `polled`.
- `psx_clk` edges while `att` is high are ignored.
- `rst`: state IDLE, `data`=1, `ack`=1, `polled`=0, counters/tx/rx/snap cleared, synchronizers set to 1.

## Timing
- Pin-edge to internal edge-detect latency: 3 `clk`.
- `data` updates 3–4 `clk` after `psx_clk` falls and must be stable before the host's rising edge.
- `ack` falls `ACK_DELAY`+1 cycles after the cycle the 8th rising edge is detected, and stays low exactly `ACK_LEN` cycles.
- `polled` is asserted the cycle after byte 4 completion is detected.
- Simultaneous `att` rise and byte completion: the `att` rise wins, with no ack and no `polled`.

## Structure
- Shared package `psx_pkg`:
  - constants `PSX_CMD_START`=8'h01, `PSX_CMD_POLL`=8'h42, `PSX_PAD_READY`=8'h5A, `PSX_IDLE_BYTE`=8'hFF;
  - FSM state enum;
  - `PSX_BYTES_DIGITAL`=5.
- One sub-module: `psx_sync_edge`, a 2-flop synchronizer plus rise/fall pulses, instanced three times.

## Test plan
- Full poll: host sends 01,42,00,00,00 with `buttons`=16'h0009 → `data` bytes FF,41,5A,F6,FF; exactly 4 ack pulses, each `ACK_LEN` cycles; `polled` once.
- Bad start: first byte 8'h81 → `data` stays 1, no ack, `polled`=0; the next `att` cycle with a valid poll succeeds.
- Coherency: `buttons` changes 16'h0000→16'hFFFF during byte 3 → bytes 3,4 = FF,FF (sampled value).
- Abort: `att` rises at bit 5 of byte 2 → next cycle `data`=1, `ack`=1, FSM IDLE; a subsequent full poll is correct.
- `rst` asserted mid-ack → `ack`=1 the next cycle; all outputs at reset values.
- Loopback with the host poller at 7 kHz `psx_clk` → host-captured 24 bits equal 5A, ~buttons[7:0], ~buttons[15:8].

Source files
------------

// File: rtl/psx_pkg.sv
// Shared constants, FSM encoding and response table for the PSX digital pad endpoint.
package psx_pkg;

    localparam logic [7:0] PSX_CMD_START = 8'h01;
    localparam logic [7:0] PSX_CMD_POLL  = 8'h42;
    localparam logic [7:0] PSX_PAD_READY = 8'h5A;
    localparam logic [7:0] PSX_IDLE_BYTE = 8'hFF;

    localparam int unsigned PSX_BYTES_DIGITAL = 5;
    localparam int unsigned PSX_BIT_CNT_W     = 3;
    localparam int unsigned PSX_BYTE_CNT_W    = 3;

    typedef enum logic [1:0] {
        PSX_IDLE   = 2'd0,
        PSX_XFER   = 2'd1,
        PSX_IGNORE = 2'd2,
        PSX_DONE   = 2'd3
    } psx_state_e;

    // Synchronized level plus single-cycle edge strobes, all aligned to the same cycle.
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } psx_edge_t;

    // Byte the pad returns at position idx of a digital poll.
    function automatic logic [7:0] psx_resp_byte(
        input logic [PSX_BYTE_CNT_W-1:0] idx,
        input logic [7:0]                id,
        input logic [15:0]               snap
    );
        logic [7:0] b;
        case (idx)
            PSX_BYTE_CNT_W'(0): b = PSX_IDLE_BYTE;
            PSX_BYTE_CNT_W'(1): b = id;
            PSX_BYTE_CNT_W'(2): b = PSX_PAD_READY;
            PSX_BYTE_CNT_W'(3): b = ~snap[7:0];
            default:            b = ~snap[15:8];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/psx_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with registered rise/fall strobes.
module psx_sync_edge
    import psx_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      din,
    output psx_edge_t sig
);

    logic meta;
    logic sync;

    // Edge strobes compare the synchronized value against the previous level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta      <= 1'b1;
            sync      <= 1'b1;
            sig.level <= 1'b1;
            sig.rise  <= 1'b0;
            sig.fall  <= 1'b0;
        end else begin
            meta      <= din;
            sync      <= meta;
            sig.level <= sync;
            sig.rise  <= sync & ~sig.level;
            sig.fall  <= ~sync & sig.level;
        end
    end

endmodule

// File: rtl/psx_pad_emulator.sv
// Digital pad endpoint: decodes the host poll, shifts back the 5-byte response and
// pulses ack after bytes 0-3.
module psx_pad_emulator
    import psx_pkg::*;
#(
    parameter int unsigned ACK_DELAY = 2,
    parameter int unsigned ACK_LEN   = 2,
    parameter logic [7:0]  ID_BYTE   = 8'h41
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psx_clk,
    input  logic        att,
    input  logic        cmd,
    input  logic [15:0] buttons,
    output logic        data,
    output logic        ack,
    output logic        polled
);

    localparam int unsigned ACK_END   = ACK_DELAY + ACK_LEN;
    localparam int unsigned ACK_CNT_W = $clog2(ACK_END + 1);

    psx_edge_t clk_e;
    psx_edge_t att_e;
    psx_edge_t cmd_e;

    psx_sync_edge u_sync_clk (.clk(clk), .rst(rst), .din(psx_clk), .sig(clk_e));
    psx_sync_edge u_sync_att (.clk(clk), .rst(rst), .din(att),     .sig(att_e));
    psx_sync_edge u_sync_cmd (.clk(clk), .rst(rst), .din(cmd),     .sig(cmd_e));

    logic unused_edges;
    assign unused_edges = &{1'b0, cmd_e.rise, cmd_e.fall, clk_e.level};

    psx_state_e                state,    state_nxt;
    logic [PSX_BIT_CNT_W-1:0]  bit_cnt,  bit_cnt_nxt;
    logic [PSX_BYTE_CNT_W-1:0] byte_cnt, byte_cnt_nxt;
    logic [7:0]                tx,       tx_nxt;
    logic [7:0]                rx,       rx_nxt;
    logic [15:0]               snap,     snap_nxt;
    logic [ACK_CNT_W-1:0]      ack_cnt,  ack_cnt_nxt;
    logic                      ack_busy, ack_busy_nxt;
    logic                      data_nxt;
    logic                      ack_nxt;
    logic                      polled_nxt;

    logic [7:0] rx_shift;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       byte_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PSX_IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx       <= '0;
            rx       <= '0;
            snap     <= '0;
            ack_cnt  <= '0;
            ack_busy <= 1'b0;
            data     <= 1'b1;
            ack      <= 1'b1;
            polled   <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            byte_cnt <= byte_cnt_nxt;
            tx       <= tx_nxt;
            rx       <= rx_nxt;
            snap     <= snap_nxt;
            ack_cnt  <= ack_cnt_nxt;
            ack_busy <= ack_busy_nxt;
            data     <= data_nxt;
            ack      <= ack_nxt;
            polled   <= polled_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        byte_cnt_nxt = byte_cnt;
        tx_nxt       = tx;
        rx_nxt       = rx;
        snap_nxt     = snap;
        ack_cnt_nxt  = ack_cnt;
        ack_busy_nxt = ack_busy;
        data_nxt     = data;
        polled_nxt   = 1'b0;
        ack_nxt      = 1'b1;

        rx_shift  = {cmd_e.level, rx[7:1]};
        sclk_rise = clk_e.rise & ~att_e.level;
        sclk_fall = clk_e.fall & ~att_e.level;
        byte_bad  = ((byte_cnt == PSX_BYTE_CNT_W'(0)) && (rx_shift != PSX_CMD_START)) ||
                    ((byte_cnt == PSX_BYTE_CNT_W'(1)) && (rx_shift != PSX_CMD_POLL));

        // Ack timer free-runs from arming; bit traffic never restarts or cancels it.
        if (ack_busy) begin
            if (ack_cnt == ACK_CNT_W'(ACK_END)) begin
                ack_busy_nxt = 1'b0;
                ack_cnt_nxt  = '0;
            end else begin
                ack_cnt_nxt = ack_cnt + ACK_CNT_W'(1);
            end
        end

        unique case (state)
            PSX_IDLE: begin
                data_nxt = 1'b1;
                if (att_e.fall) begin
                    tx_nxt       = PSX_IDLE_BYTE;
                    rx_nxt       = '0;
                    bit_cnt_nxt  = '0;
                    byte_cnt_nxt = '0;
                    state_nxt    = PSX_XFER;
                end
            end
            PSX_XFER: begin
                if (sclk_fall) begin
                    data_nxt = tx[0];
                    tx_nxt   = {1'b1, tx[7:1]};
                end
                if (sclk_rise) begin
                    rx_nxt      = rx_shift;
                    bit_cnt_nxt = bit_cnt + PSX_BIT_CNT_W'(1);
                    if (bit_cnt == PSX_BIT_CNT_W'(7)) begin
                        if (byte_bad) begin
                            state_nxt = PSX_IGNORE;
                            data_nxt  = 1'b1;
                        end else if (byte_cnt == PSX_BYTE_CNT_W'(PSX_BYTES_DIGITAL - 1)) begin
                            state_nxt  = PSX_DONE;
                            data_nxt   = 1'b1;
                            polled_nxt = 1'b1;
                        end else begin
                            tx_nxt       = psx_resp_byte(byte_cnt + PSX_BYTE_CNT_W'(1), ID_BYTE, snap);
                            byte_cnt_nxt = byte_cnt + PSX_BYTE_CNT_W'(1);
                            ack_busy_nxt = 1'b1;
                            ack_cnt_nxt  = ACK_CNT_W'(1);
                            // Both button bytes come from this one sample.
                            if (byte_cnt == PSX_BYTE_CNT_W'(1)) begin
                                snap_nxt = buttons;
                            end
                        end
                    end
                end
            end
            PSX_IGNORE: data_nxt = 1'b1;
            PSX_DONE:   data_nxt = 1'b1;
            default:    state_nxt = PSX_IDLE;
        endcase

        // Host releasing attention aborts everything, including a same-cycle byte completion.
        if (att_e.rise) begin
            state_nxt    = PSX_IDLE;
            data_nxt     = 1'b1;
            ack_busy_nxt = 1'b0;
            ack_cnt_nxt  = '0;
            polled_nxt   = 1'b0;
        end

        ack_nxt = ~(ack_busy_nxt &&
                    (ack_cnt_nxt > ACK_CNT_W'(ACK_DELAY)) &&
                    (ack_cnt_nxt <= ACK_CNT_W'(ACK_END)));
    end

endmodule
